// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : mode timing constants, display-flag bundle, width helpers
// Rev 1.0
// ============================================================================
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int M640_H_ACTIVE = 640;
    localparam int M640_H_FP     = 16;
    localparam int M640_H_SYNC   = 96;
    localparam int M640_H_BP     = 48;
    localparam int M640_V_ACTIVE = 480;
    localparam int M640_V_FP     = 10;
    localparam int M640_V_SYNC   = 2;
    localparam int M640_V_BP     = 33;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int M800_H_ACTIVE = 800;
    localparam int M800_H_FP     = 40;
    localparam int M800_H_SYNC   = 128;
    localparam int M800_H_BP     = 88;
    localparam int M800_V_ACTIVE = 600;
    localparam int M800_V_FP     = 1;
    localparam int M800_V_SYNC   = 4;
    localparam int M800_V_BP     = 23;

    // Flags carried from the request timeline to the display timeline
    typedef struct packed {
        logic data_req;
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } disp_t;

    localparam int DISP_W = $bits(disp_t);

    function automatic int cd_width(input int r_w, input int g_w, input int b_w);
        return r_w + g_w + b_w;
    endfunction

    // Bits needed to hold 0..n-1, never less than one
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// vga_delay_line : CE-gated shift register with synchronous load of RESET_VAL
// Rev 1.0
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else if (ce_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised VGA raster generator with request/display split
// Rev 1.0
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = M640_H_ACTIVE,
    parameter int H_FP     = M640_H_FP,
    parameter int H_SYNC   = M640_H_SYNC,
    parameter int H_BP     = M640_H_BP,
    parameter int V_ACTIVE = M640_V_ACTIVE,
    parameter int V_FP     = M640_V_FP,
    parameter int V_SYNC   = M640_V_SYNC,
    parameter int V_BP     = M640_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LATENCY  = 1,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int FC_W     = 16,
    localparam int CD_W    = cd_width(R_W, G_W, B_W)
) (
    input  logic            CLK_PIXEL,
    input  logic            RESET,
    input  logic            CE,
    input  logic [CD_W-1:0] COLOR_DATA_IN,
    output logic [XW-1:0]   CURX,
    output logic [YW-1:0]   CURY,
    output logic            DATA_REQ,
    output logic            LINE_START,
    output logic            FRAME_START,
    output logic [FC_W-1:0] FRAME_COUNT,
    output logic            HS,
    output logic            VS,
    output logic            HBLANK,
    output logic            VBLANK,
    output logic            BLANK,
    output logic [R_W-1:0]  RED,
    output logic [G_W-1:0]  GREEN,
    output logic [B_W-1:0]  BLUE
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW   = clog2_w(H_TOT);
    localparam int VCW   = clog2_w(V_TOT);

    localparam logic [HCW-1:0] C_H_ACT_END = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] C_HS_BEG    = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] C_HS_END    = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCW-1:0] C_H_LAST    = HCW'(H_TOT - 1);
    localparam logic [VCW-1:0] C_V_ACT_END = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] C_VS_BEG    = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] C_VS_END    = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0] C_V_LAST    = VCW'(V_TOT - 1);

    localparam disp_t C_IDLE = '{data_req: 1'b0, hblank: 1'b1, vblank: 1'b1,
                                 hsync: ~HS_POL, vsync: ~VS_POL};

    logic [HCW-1:0]  hc_q, hc_d;
    logic [VCW-1:0]  vc_q, vc_d;
    disp_t           req_q, req_d;
    disp_t           w_disp;
    logic [XW-1:0]   curx_q, curx_d;
    logic [YW-1:0]   cury_q, cury_d;
    logic [CD_W-1:0] rgb_q;
    logic [CD_W-1:0] w_rgb;
    logic [FC_W-1:0] fc_q;
    logic            armed_q;
    logic            line_start_q, frame_start_q;
    logic            w_h_act, w_v_act, w_active;
    logic            w_line_wrap, w_frame_wrap;

    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == C_H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == C_V_LAST) ? '0 : vc_q + 1'b1;
        end
    end

    assign w_h_act  = (hc_q < C_H_ACT_END);
    assign w_v_act  = (vc_q < C_V_ACT_END);
    assign w_active = w_h_act && w_v_act;

    always_comb begin
        req_d          = C_IDLE;
        req_d.data_req = w_active;
        req_d.hblank   = !w_h_act;
        req_d.vblank   = !w_v_act;
        req_d.hsync    = (hc_q >= C_HS_BEG && hc_q < C_HS_END) ? HS_POL : ~HS_POL;
        req_d.vsync    = (vc_q >= C_VS_BEG && vc_q < C_VS_END) ? VS_POL : ~VS_POL;
        curx_d         = w_active ? XW'(hc_q) : '0;
        cury_d         = w_active ? YW'(vc_q) : '0;
    end

    // armed_q keeps the post-reset (0,0) request from looking like a wrap
    assign w_line_wrap  = CE && armed_q && (hc_q == '0);
    assign w_frame_wrap = w_line_wrap && (vc_q == '0);

    always_ff @(posedge CLK_PIXEL) begin
        if (RESET) begin
            hc_q    <= '0;
            vc_q    <= '0;
            req_q   <= C_IDLE;
            curx_q  <= '0;
            cury_q  <= '0;
            rgb_q   <= '0;
            fc_q    <= '0;
            armed_q <= 1'b0;
        end else if (CE) begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            req_q   <= req_d;
            curx_q  <= curx_d;
            cury_q  <= cury_d;
            rgb_q   <= COLOR_DATA_IN;
            armed_q <= 1'b1;
            if (w_frame_wrap) fc_q <= fc_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (RESET) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= w_line_wrap;
            frame_start_q <= w_frame_wrap;
        end
    end

    vga_delay_line #(
        .WIDTH     (DISP_W),
        .DEPTH     (LATENCY),
        .RESET_VAL (C_IDLE)
    ) u_disp_dly (
        .clk_i (CLK_PIXEL),
        .rst_i (RESET),
        .ce_i  (CE),
        .d_i   (req_q),
        .q_o   (w_disp)
    );

    // Colour sampled alongside the final stage, so the delayed request flag gates it
    assign w_rgb = w_disp.data_req ? rgb_q : '0;

    assign CURX        = curx_q;
    assign CURY        = cury_q;
    assign DATA_REQ    = req_q.data_req;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;
    assign FRAME_COUNT = fc_q;
    assign HS          = w_disp.hsync;
    assign VS          = w_disp.vsync;
    assign HBLANK      = w_disp.hblank;
    assign VBLANK      = w_disp.vblank;
    assign BLANK       = w_disp.hblank | w_disp.vblank;
    assign RED         = w_rgb[CD_W-1 -: R_W];
    assign GREEN       = w_rgb[B_W +: G_W];
    assign BLUE        = w_rgb[0 +: B_W];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : directed checks of a tiny LATENCY=3 mode and 800x600 mode
// Rev 1.0
// ============================================================================
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk;
    logic rst_t, ce_t, rst_b;
    logic [7:0] color_t;
    logic [7:0] cli1_q, cli2_q;

    logic [7:0] t_curx, t_cury;
    logic       t_req, t_ls, t_fs, t_hs, t_vs, t_hb, t_vb, t_bl;
    logic [3:0] t_fc;
    logic [2:0] t_r, t_g;
    logic [1:0] t_b;

    logic [9:0]  b_curx, b_cury;
    logic        b_req, b_ls, b_fs, b_hs, b_vs, b_hb, b_vb, b_bl;
    logic [15:0] b_fc;
    logic [2:0]  b_r, b_g;
    logic [1:0]  b_b;

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;
    int cyc   = 0;
    int fs_last = -1;
    int period_exp = 56;
    int fs_count = 0;
    int big_cyc = 0;
    int big_last = -1;
    int big_hs_cnt = 0;
    int big_req_cnt = 0;
    int big_lines = 0;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .LATENCY(3),
        .R_W(3), .G_W(3), .B_W(2), .XW(8), .YW(8), .FC_W(4)
    ) u_tiny (
        .CLK_PIXEL(clk), .RESET(rst_t), .CE(ce_t), .COLOR_DATA_IN(color_t),
        .CURX(t_curx), .CURY(t_cury), .DATA_REQ(t_req),
        .LINE_START(t_ls), .FRAME_START(t_fs), .FRAME_COUNT(t_fc),
        .HS(t_hs), .VS(t_vs), .HBLANK(t_hb), .VBLANK(t_vb), .BLANK(t_bl),
        .RED(t_r), .GREEN(t_g), .BLUE(t_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(M800_H_ACTIVE), .H_FP(M800_H_FP), .H_SYNC(M800_H_SYNC), .H_BP(M800_H_BP),
        .V_ACTIVE(M800_V_ACTIVE), .V_FP(M800_V_FP), .V_SYNC(M800_V_SYNC), .V_BP(M800_V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(1),
        .R_W(3), .G_W(3), .B_W(2), .XW(10), .YW(10), .FC_W(16)
    ) u_big (
        .CLK_PIXEL(clk), .RESET(rst_b), .CE(1'b1), .COLOR_DATA_IN(8'h00),
        .CURX(b_curx), .CURY(b_cury), .DATA_REQ(b_req),
        .LINE_START(b_ls), .FRAME_START(b_fs), .FRAME_COUNT(b_fc),
        .HS(b_hs), .VS(b_vs), .HBLANK(b_hb), .VBLANK(b_vb), .BLANK(b_bl),
        .RED(b_r), .GREEN(b_g), .BLUE(b_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Client with two enabled register stages: data for CURX lands as the third stage loads
    initial begin
        cli1_q = '0;
        cli2_q = '0;
    end
    always @(posedge clk) begin
        if (ce_t) begin
            cli1_q <= t_curx;
            cli2_q <= cli1_q;
        end
    end
    assign color_t = cli2_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Tiny mode: H_TOT=8 (sync at 5,6), V_TOT=7 (sync lines 4,5), 56 clocks/frame.
    // After n enabled edges since reset the request shows position n-1, the display n-4.
    task automatic check_tiny(input bit live);
        int p, hc, vc, d, dh, dv;
        int e_req, e_x, e_y, e_ls, e_fs, e_fc, e_hs, e_vs, e_hb, e_vb, e_rgb;
        e_req = 0; e_x = 0; e_y = 0;
        if (n > 0) begin
            p  = n - 1;
            hc = p % 8;
            vc = (p / 8) % 7;
            if (hc < 4 && vc < 3) begin
                e_req = 1; e_x = hc; e_y = vc;
            end
        end
        e_ls = (live && n >= 2 && ((n - 1) % 8) == 0)  ? 1 : 0;
        e_fs = (live && n >= 2 && ((n - 1) % 56) == 0) ? 1 : 0;
        e_fc = (n >= 2) ? (((n - 1) / 56) % 16) : 0;
        d = n - 4;
        if (d < 0) begin
            e_hs = 0; e_vs = 1; e_hb = 1; e_vb = 1; e_rgb = 0;
        end else begin
            dh   = d % 8;
            dv   = (d / 8) % 7;
            e_hb = (dh >= 4) ? 1 : 0;
            e_vb = (dv >= 3) ? 1 : 0;
            e_hs = (dh == 5 || dh == 6) ? 1 : 0;
            e_vs = (dv == 4 || dv == 5) ? 0 : 1;
            e_rgb = (e_hb == 0 && e_vb == 0) ? dh : 0;
        end
        chk("curx",        32'(t_curx), 32'(e_x));
        chk("cury",        32'(t_cury), 32'(e_y));
        chk("data_req",    32'(t_req),  32'(e_req));
        chk("line_start",  32'(t_ls),   32'(e_ls));
        chk("frame_start", 32'(t_fs),   32'(e_fs));
        chk("frame_count", 32'(t_fc),   32'(e_fc));
        chk("hs",          32'(t_hs),   32'(e_hs));
        chk("vs",          32'(t_vs),   32'(e_vs));
        chk("hblank",      32'(t_hb),   32'(e_hb));
        chk("vblank",      32'(t_vb),   32'(e_vb));
        chk("blank",       32'(t_bl),   32'((e_hb | e_vb) != 0 ? 1 : 0));
        chk("rgb",         32'({t_r, t_g, t_b}), 32'(e_rgb));
    endtask

    task automatic step(input bit ce_v, input bit rst_v);
        ce_t  = ce_v;
        rst_t = rst_v;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_v) n = 0;
        else if (ce_v) n++;
        check_tiny(ce_v && !rst_v);
        if (t_fs) begin
            fs_count++;
            if (fs_last >= 0) chk("frame_period", 32'(cyc - fs_last), 32'(period_exp));
            fs_last = cyc;
        end
        if (!rst_b) begin
            big_cyc++;
            if (b_ls) begin
                if (big_last >= 0) begin
                    chk("big_line_period", 32'(big_cyc - big_last), 32'd1056);
                    chk("big_hs_high",     32'(big_hs_cnt),         32'd128);
                    chk("big_req_per_line", 32'(big_req_cnt),       32'd800);
                    big_lines++;
                end
                big_last    = big_cyc;
                big_hs_cnt  = 0;
                big_req_cnt = 0;
            end
            big_hs_cnt  += b_hs ? 1 : 0;
            big_req_cnt += b_req ? 1 : 0;
        end
    endtask

    initial begin
        ce_t  = 1'b1;
        rst_t = 1'b1;
        rst_b = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("big_reset_hs",    32'(b_hs), 32'd0);
        chk("big_reset_vs",    32'(b_vs), 32'd0);
        chk("big_reset_blank", 32'(b_bl), 32'd1);
        rst_b = 1'b0;

        // Continuous enable across 17 frames: frame counter wraps 15 -> 0 -> 1
        period_exp = 56;
        repeat (17 * 56 + 10) step(1'b1, 1'b0);
        chk("fc_after_17_frames", 32'(t_fc), 32'd1);

        // Half-rate enable doubles the frame period; strobes must not repeat
        fs_last    = -1;
        fs_count   = 0;
        period_exp = 112;
        repeat (130) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        chk("halfrate_frames_seen", 32'(fs_count >= 2 ? 1 : 0), 32'd1);

        // Mid-frame reset with CE low: reset wins, then counting restarts at (0,0)
        fs_last    = -1;
        period_exp = 56;
        step(1'b0, 1'b1);
        chk("reset_curx", 32'(t_curx), 32'd0);
        chk("reset_fc",   32'(t_fc),   32'd0);
        repeat (100) step(1'b1, 1'b0);

        // Let the 800x600 instance complete two full measured lines
        for (int i = 0; i < 4000 && big_lines < 2; i++) step(1'b1, 1'b0);
        chk("big_lines_measured", 32'(big_lines >= 2 ? 1 : 0), 32'd1);
        chk("big_vs_inactive",    32'(b_vs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
